// File: rtl/hyperram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one HyperRAM s0 port among NPORTS masters.
// Strobes are held for a fixed time, then dropped for a gap so every access starts on a fresh edge.
module hyperram_port_arbiter #(
  parameter int          NPORTS     = 2,
  parameter int          WR_CYCLES  = 64,
  parameter int          GAP_CYCLES = 12,
  parameter int          TIMEOUT    = 1023,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
  localparam int         GW         = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS*32-1:0] req_address,
  input  logic [NPORTS-1:0]    req_read,
  input  logic [NPORTS-1:0]    req_write,
  input  logic [NPORTS*32-1:0] req_writedata,
  output logic [NPORTS-1:0]    req_waitrequest,
  output logic [31:0]          req_readdata,
  output logic [NPORTS-1:0]    req_readdatavalid,
  output logic [31:0]          mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_writedata,
  input  logic [31:0]          mem_readdata,
  input  logic                 mem_readdatavalid,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int MAXWG = (WR_CYCLES > GAP_CYCLES) ? WR_CYCLES : GAP_CYCLES;
  localparam int MAXC  = (MAXWG > TIMEOUT) ? MAXWG : TIMEOUT;
  localparam int CW    = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [GW-1:0] rr, pick, cand;
  logic          any_req;
  logic          op_rd;
  logic          rd_expired;
  logic [31:0]   addr_arr  [NPORTS];
  logic [31:0]   wdata_arr [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
    assign addr_arr[g]  = req_address[32*g +: 32];
    assign wdata_arr[g] = req_writedata[32*g +: 32];
  end

  // First requester at or above the RR pointer, wrapping around.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      cand = GW'((32'(rr) + i) % NPORTS);
      if (!any_req && (req_read[cand] || req_write[cand])) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign rd_expired = (cnt == CW'(TIMEOUT - 1));
  assign mem_read   = ((state == ISSUE) && op_rd) || (state == WAIT_RD);
  assign mem_write  = ((state == ISSUE) && !op_rd) || (state == WAIT_WR);
  assign busy       = (state != IDLE);

  always_comb begin
    req_waitrequest = '1;
    if (state == ISSUE) req_waitrequest[grant_id] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Write count starts at 1 so the ISSUE cycle is part of the WR_CYCLES strobe width.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = op_rd ? WAIT_RD : WAIT_WR;
        cnt_nxt   = op_rd ? CW'(0) : CW'(1);
      end
      WAIT_RD: begin
        if (mem_readdatavalid || rd_expired) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_WR: begin
        if (cnt == CW'(WR_CYCLES - 1)) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_id          <= '0;
      rr                <= '0;
      op_rd             <= 1'b0;
      mem_address       <= '0;
      mem_writedata     <= '0;
      req_readdata      <= '0;
      req_readdatavalid <= '0;
      timeout_err       <= 1'b0;
    end else begin
      req_readdatavalid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id      <= pick;
            mem_address   <= addr_arr[pick];
            mem_writedata <= wdata_arr[pick];
            op_rd         <= req_read[pick];
          end
        end
        ISSUE: rr <= (grant_id == GW'(NPORTS - 1)) ? '0 : grant_id + 1'b1;
        WAIT_RD: begin
          if (mem_readdatavalid) begin
            req_readdata                <= mem_readdata;
            req_readdatavalid[grant_id] <= 1'b1;
          end else if (rd_expired) begin
            req_readdata                <= ERR_DATA;
            req_readdatavalid[grant_id] <= 1'b1;
            timeout_err                 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_port_arbiter.sv
// Self-checking bench for hyperram_port_arbiter: controller model with random latency/data,
// transaction-level expectations derived from strobe width, gap and round-robin rules.
module tb_hyperram_port_arbiter;
  localparam int NP   = 2;
  localparam int WRC  = 64;
  localparam int GAPC = 12;
  localparam int TO   = 1023;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NP*32-1:0] req_address = '0;
  logic [NP-1:0]   req_read = '0;
  logic [NP-1:0]   req_write = '0;
  logic [NP*32-1:0] req_writedata = '0;
  logic [NP-1:0]   req_waitrequest;
  logic [31:0]     req_readdata;
  logic [NP-1:0]   req_readdatavalid;
  logic [31:0]     mem_address;
  logic            mem_read;
  logic            mem_write;
  logic [31:0]     mem_writedata;
  logic [31:0]     mem_readdata = '0;
  logic            mem_readdatavalid = 1'b0;
  logic [0:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  int total = 0;
  int bad   = 0;

  hyperram_port_arbiter #(.NPORTS(NP), .WR_CYCLES(WRC), .GAP_CYCLES(GAPC),
                          .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_writedata(req_writedata), .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Controller model: answers a read lat cycles after its first strobe cycle.
  bit          resp_on = 1'b0, rand_lat = 1'b0, rand_data = 1'b0, pulse_now = 1'b0;
  int          fixed_lat = 1, last_lat = 0, k = 0;
  logic [31:0] fixed_data = '0, rd_val;
  logic        rd_prev = 1'b0;
  logic [31:0] resp_q[$];

  always begin
    @(posedge clk); #1;
    mem_readdatavalid = 1'b0;
    if (pulse_now) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = 32'h5555_AAAA;
      pulse_now         = 1'b0;
    end else if (mem_read) begin
      if (!rd_prev) begin
        k        = 1;
        last_lat = rand_lat ? int'($urandom_range(1, 60)) : fixed_lat;
      end else begin
        k++;
      end
      if (resp_on && k == last_lat + 1) begin
        rd_val            = rand_data ? $urandom : fixed_data;
        mem_readdata      = rd_val;
        mem_readdatavalid = 1'b1;
        resp_q.push_back(rd_val);
      end
    end
    rd_prev = mem_read;
  end

  // Per-transaction measurements filled by observe_txn.
  int m_accept, m_wq_low, m_other_low, m_rd_hi, m_wr_hi, m_pulses, m_pulse_bad;
  int m_pulse_cyc, m_gap, m_addr_bad, m_done;
  logic [31:0] m_pulse_data;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_read = '0; req_write = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic observe_txn(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                             input bit chk_wd, input int budget);
    bool_seen: begin end
    m_accept = 0; m_wq_low = 0; m_other_low = 0; m_rd_hi = 0; m_wr_hi = 0; m_pulses = 0;
    m_pulse_bad = 0; m_pulse_cyc = 0; m_gap = 0; m_addr_bad = 0; m_done = 0; m_pulse_data = '0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (!req_waitrequest[port]) begin
        m_wq_low++;
        if (m_accept == 0) m_accept = c;
        req_read[port] = 1'b0; req_write[port] = 1'b0;
      end
      for (int p = 0; p < NP; p++)
        if (p != port && !req_waitrequest[p]) m_other_low++;
      if (mem_read) m_rd_hi++;
      if (mem_write) m_wr_hi++;
      if ((mem_read || mem_write) &&
          (mem_address !== addr || (chk_wd && mem_writedata !== wdata))) m_addr_bad++;
      if (req_readdatavalid != '0) begin
        m_pulses++;
        if (req_readdatavalid != NP'(1 << port)) m_pulse_bad++;
        m_pulse_data = req_readdata;
        m_pulse_cyc  = c;
      end
      if (busy && !mem_read && !mem_write && (m_rd_hi + m_wr_hi) > 0) m_gap++;
      if (!busy && (m_rd_hi + m_wr_hi) > 0) begin
        m_done = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    total++; if (req_waitrequest !== '1) begin bad++; $display("FAIL reset_waitreq got %b want 11", req_waitrequest); end
    total++; if (req_readdatavalid !== '0 || req_readdata !== '0) begin bad++; $display("FAIL reset_rdv got %b/%h want 0/0", req_readdatavalid, req_readdata); end
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL reset_strobes got %b%b want 00", mem_read, mem_write); end
    total++; if (mem_address !== '0 || mem_writedata !== '0) begin bad++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_address, mem_writedata); end
    total++; if (grant_id !== '0 || busy !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL reset_status got %b%b%b want 000", grant_id, busy, timeout_err); end
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    resp_on = 1; rand_lat = 0; rand_data = 0; fixed_lat = 40; fixed_data = 32'h1234_5678;
    resp_q.delete();
    req_address[31:0] = 32'h100; req_read[0] = 1'b1;
    observe_txn(0, 32'h100, '0, 1'b0, 300);
    total++; if (m_accept !== 1 || m_wq_low !== 1) begin bad++; $display("FAIL rd_accept got at=%0d n=%0d want 1/1", m_accept, m_wq_low); end
    total++; if (m_rd_hi !== 41 || m_wr_hi !== 0) begin bad++; $display("FAIL rd_width got %0d/%0d want 41/0", m_rd_hi, m_wr_hi); end
    total++; if (m_pulses !== 1 || m_pulse_bad !== 0 || m_pulse_cyc !== 42) begin bad++; $display("FAIL rd_pulse got n=%0d bad=%0d cyc=%0d want 1/0/42", m_pulses, m_pulse_bad, m_pulse_cyc); end
    total++; if (m_pulse_data !== 32'h1234_5678) begin bad++; $display("FAIL rd_data got %h want 12345678", m_pulse_data); end
    total++; if (m_gap !== GAPC || m_done !== 41 + GAPC + 1 || m_addr_bad !== 0) begin bad++; $display("FAIL rd_gap got gap=%0d done=%0d abad=%0d want %0d/%0d/0", m_gap, m_done, m_addr_bad, GAPC, 41 + GAPC + 1); end
  endtask

  task automatic test_single_write();
    req_address[63:32] = 32'h200; req_writedata[63:32] = 32'hCAFE_0001; req_write[1] = 1'b1;
    observe_txn(1, 32'h200, 32'hCAFE_0001, 1'b1, 300);
    total++; if (m_accept !== 1 || m_wq_low !== 1 || m_other_low !== 0) begin bad++; $display("FAIL wr_accept got at=%0d n=%0d oth=%0d want 1/1/0", m_accept, m_wq_low, m_other_low); end
    total++; if (m_wr_hi !== WRC || m_rd_hi !== 0) begin bad++; $display("FAIL wr_width got %0d/%0d want %0d/0", m_wr_hi, m_rd_hi, WRC); end
    total++; if (m_addr_bad !== 0 || m_pulses !== 0) begin bad++; $display("FAIL wr_bus got abad=%0d pulses=%0d want 0/0", m_addr_bad, m_pulses); end
    total++; if (m_gap !== GAPC || m_done !== WRC + GAPC + 1) begin bad++; $display("FAIL wr_busy got gap=%0d done=%0d want %0d/%0d", m_gap, m_done, GAPC, WRC + GAPC + 1); end
  endtask

  task automatic test_rd_wr_same();
    fixed_lat = 7; fixed_data = 32'h0BAD_F00D; resp_q.delete();
    req_address[31:0] = 32'h300; req_read[0] = 1'b1; req_write[0] = 1'b1;
    observe_txn(0, 32'h300, '0, 1'b0, 300);
    total++; if (m_rd_hi !== 8 || m_wr_hi !== 0) begin bad++; $display("FAIL rdwr_op got rd=%0d wr=%0d want 8/0", m_rd_hi, m_wr_hi); end
    total++; if (m_pulses !== 1 || m_pulse_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL rdwr_data got n=%0d d=%h want 1/0badf00d", m_pulses, m_pulse_data); end
  endtask

  task automatic test_timeout();
    resp_on = 0;
    req_address[63:32] = 32'h400; req_read[1] = 1'b1;
    observe_txn(1, 32'h400, '0, 1'b0, 2000);
    total++; if (m_rd_hi !== TO + 1 || m_pulse_cyc !== TO + 2) begin bad++; $display("FAIL to_len got rd=%0d cyc=%0d want %0d/%0d", m_rd_hi, m_pulse_cyc, TO + 1, TO + 2); end
    total++; if (m_pulses !== 1 || m_pulse_bad !== 0 || m_pulse_data !== ERRD) begin bad++; $display("FAIL to_data got n=%0d bad=%0d d=%h want 1/0/%h", m_pulses, m_pulse_bad, m_pulse_data, ERRD); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag got %b want 1", timeout_err); end
    resp_on = 1; fixed_lat = 3; fixed_data = 32'h0000_600D; resp_q.delete();
    req_address[31:0] = 32'h500; req_read[0] = 1'b1;
    observe_txn(0, 32'h500, '0, 1'b0, 300);
    total++; if (m_pulse_data !== 32'h0000_600D || m_pulse_bad !== 0) begin bad++; $display("FAIL to_after_data got %h want 0000600d", m_pulse_data); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got %b want 1", timeout_err); end
  endtask

  task automatic test_random_rr();
    int ptr, owner, width, exp_done;
    logic [NP-1:0] mask;
    logic [1:0]    op [NP];
    logic [31:0]   a [NP];
    logic [31:0]   w [NP];
    logic [31:0]   exp_d;
    bit            exp_rd;
    do_reset();
    ptr = 0; resp_on = 1; rand_lat = 1; rand_data = 1;
    for (int it = 0; it < 12; it++) begin
      resp_q.delete();
      mask = NP'($urandom_range(1, (1 << NP) - 1));
      for (int p = 0; p < NP; p++) begin
        op[p] = 2'($urandom_range(1, 3));
        a[p]  = $urandom; w[p] = $urandom;
        req_address[32*p +: 32]   = a[p];
        req_writedata[32*p +: 32] = w[p];
        req_read[p]  = mask[p] & op[p][0];
        req_write[p] = mask[p] & op[p][1];
      end
      owner = -1;
      for (int i = 0; i < NP; i++)
        if (owner < 0 && mask[(ptr + i) % NP]) owner = (ptr + i) % NP;
      ptr    = (owner + 1) % NP;
      exp_rd = op[owner][0];
      observe_txn(owner, a[owner], w[owner], !exp_rd, 1500);
      req_read = '0; req_write = '0;
      width    = exp_rd ? last_lat + 1 : WRC;
      exp_done = width + GAPC + 1;
      total++; if (m_accept !== 1 || m_other_low !== 0 || m_done !== exp_done) begin bad++; $display("FAIL rr_grant it=%0d owner=%0d got at=%0d oth=%0d done=%0d want 1/0/%0d", it, owner, m_accept, m_other_low, m_done, exp_done); end
      total++; if ((exp_rd ? m_rd_hi : m_wr_hi) !== width || (exp_rd ? m_wr_hi : m_rd_hi) !== 0 || m_addr_bad !== 0) begin bad++; $display("FAIL rr_strobe it=%0d got rd=%0d wr=%0d abad=%0d want width %0d rd=%0b", it, m_rd_hi, m_wr_hi, m_addr_bad, width, exp_rd); end
      exp_d = (resp_q.size() > 0) ? resp_q.pop_front() : ~m_pulse_data;
      total++; if (m_pulses !== (exp_rd ? 1 : 0) || m_pulse_bad !== 0 || (exp_rd && m_pulse_data !== exp_d)) begin bad++; $display("FAIL rr_resp it=%0d got n=%0d bad=%0d d=%h want n=%0d d=%h", it, m_pulses, m_pulse_bad, m_pulse_data, exp_rd ? 1 : 0, exp_d); end
    end
  endtask

  task automatic test_reset_mid_read();
    int acc, pulses, busy_seen;
    resp_on = 0; rand_lat = 0;
    req_address[31:0] = 32'h700; req_read[0] = 1'b1;
    acc = 0;
    for (int c = 0; c < 10 && acc == 0; c++) begin
      tick();
      if (!req_waitrequest[0]) acc = 1;
    end
    req_read = '0;
    total++; if (acc !== 1) begin bad++; $display("FAIL mid_accept got %0d want 1", acc); end
    repeat (5) tick();
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || req_waitrequest !== '1) begin bad++; $display("FAIL mid_reset_ctl got busy=%b rd=%b wr=%b wq=%b want 0/0/0/11", busy, mem_read, mem_write, req_waitrequest); end
    total++; if (req_readdatavalid !== '0 || grant_id !== '0 || mem_address !== '0 || timeout_err !== 1'b0) begin bad++; $display("FAIL mid_reset_regs got rdv=%b g=%b a=%h te=%b want 0/0/0/0", req_readdatavalid, grant_id, mem_address, timeout_err); end
    rst = 1'b1; pulse_now = 1'b1;
    pulses = 0; busy_seen = 0;
    repeat (20) begin
      tick();
      if (req_readdatavalid != '0) pulses++;
      if (busy) busy_seen++;
    end
    total++; if (pulses !== 0 || busy_seen !== 0) begin bad++; $display("FAIL mid_late_valid got pulses=%0d busy=%0d want 0/0", pulses, busy_seen); end
    req_read = '1; acc = 0;
    for (int c = 0; c < 10 && acc == 0; c++) begin
      tick();
      if (req_waitrequest != '1) acc = 1;
    end
    req_read = '0;
    total++; if (req_waitrequest !== 2'b10) begin bad++; $display("FAIL mid_next_grant got wq=%b want 10", req_waitrequest); end
    resp_on = 1; fixed_lat = 2;
    acc = 0;
    for (int c = 0; c < 300 && acc == 0; c++) begin
      tick();
      if (!busy) acc = 1;
    end
    total++; if (acc !== 1) begin bad++; $display("FAIL mid_drain got idle=%0d want 1", acc); end
  endtask

  task automatic test_contention();
    int exp_owner, cur_owner, width, last_rise, n_rise, n_p, abad, wr_seen;
    logic [31:0]   cur_addr [NP];
    logic [31:0]   txn_addr, exp_d;
    logic [NP-1:0] onehot;
    logic          prev_rd;
    do_reset();
    resp_on = 1; rand_lat = 1; rand_data = 1; resp_q.delete();
    for (int p = 0; p < NP; p++) begin
      cur_addr[p] = $urandom;
      req_address[32*p +: 32] = cur_addr[p];
    end
    req_read = '1;
    exp_owner = 0; cur_owner = 0; width = 0; last_rise = 0; n_rise = 0; n_p = 0;
    abad = 0; wr_seen = 0; txn_addr = '0; prev_rd = 1'b0;
    for (int c = 1; c <= 3000 && n_p < 8; c++) begin
      tick();
      if (mem_read && !prev_rd) begin
        if (n_rise > 0) begin
          total++; if (c - last_rise !== width + GAPC + 1) begin bad++; $display("FAIL cont_spacing got %0d want %0d", c - last_rise, width + GAPC + 1); end
        end
        onehot = '1; onehot[exp_owner] = 1'b0;
        total++; if (req_waitrequest !== onehot) begin bad++; $display("FAIL cont_grant got wq=%b want %b", req_waitrequest, onehot); end
        txn_addr = cur_addr[exp_owner];
        cur_addr[exp_owner] = $urandom;
        req_address[32*exp_owner +: 32] = cur_addr[exp_owner];
        cur_owner = exp_owner;
        exp_owner = (exp_owner + 1) % NP;
        width = 0; last_rise = c; n_rise++;
      end
      if (mem_read) begin
        width++;
        if (mem_address !== txn_addr) abad++;
      end
      if (mem_write) wr_seen++;
      if (req_readdatavalid != '0) begin
        n_p++;
        exp_d  = (resp_q.size() > 0) ? resp_q.pop_front() : ~req_readdata;
        onehot = '0; onehot[cur_owner] = 1'b1;
        total++; if (req_readdatavalid !== onehot || req_readdata !== exp_d) begin bad++; $display("FAIL cont_resp got rdv=%b d=%h want %b %h", req_readdatavalid, req_readdata, onehot, exp_d); end
      end
      prev_rd = mem_read;
    end
    req_read = '0;
    total++; if (n_p !== 8 || abad !== 0 || wr_seen !== 0) begin bad++; $display("FAIL cont_summary got pulses=%0d abad=%0d wr=%0d want 8/0/0", n_p, abad, wr_seen); end
    for (int c = 0; c < 300 && busy; c++) tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_rd_wr_same();
    test_timeout();
    test_random_rr();
    test_reset_mid_read();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
